fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end; successor to the single-cycle PC/+4/instruction-memory path.
- Owns the PC register (async active-low reset to a reset vector) and issues requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions, tagged with their PC, in a FIFO.
- Presents the buffered instructions to decode over a valid/ready handshake; jump/branch redirects flush the buffer.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = '0;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-side bus: instruction-memory read port plus the decode-facing handshake.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pc_plus4;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
    input  imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
    output imem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched instructions; flush empties it and wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // The upstream credit scheme must make a push into a full buffer impossible.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    (push && !do_pop && !flush) |-> (count != CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues credit-limited imem reads and buffers
// PC-tagged instructions for decode; a redirect flushes everything in flight.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  fetch_if.master         bus,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            kill;
  logic            pop;
  logic            push;
  logic            credit_ok;
  logic            head_valid;
  logic [CW-1:0]   count;
  logic [OW-1:0]   occupancy;
  entry_t          push_data;
  entry_t          head;

  assign pop = head_valid & bus.instr_ready;
  // Slots owed to a read still in flight are reserved so a push never finds the buffer full.
  assign occupancy = OW'(count) + OW'(inflight) - OW'(pop);
  assign credit_ok = (occupancy < OW'(DEPTH));

  assign bus.imem_req  = reset_n & ~redirect_valid & credit_ok;
  assign bus.imem_addr = fetch_pc;

  assign push      = inflight & ~kill;
  assign push_data = '{pc: req_pc, instr: bus.imem_rdata};

  assign bus.instr_valid    = head_valid;
  assign bus.instr          = head.instr;
  assign bus.instr_pc       = head.pc;
  assign bus.instr_pc_plus4 = head.pc + STEP;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc   <= RESET_PC;
      req_pc     <= RESET_PC;
      inflight   <= 1'b0;
      kill       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      inflight   <= bus.imem_req;
      req_pc     <= fetch_pc;
      kill       <= redirect_valid & inflight;
      misaligned <= redirect_valid & (redirect_target[1:0] != 2'b00);
      if (redirect_valid)
        fetch_pc <= {redirect_target[XLEN-1:2], 2'b00};
      else if (bus.imem_req)
        fetch_pc <= fetch_pc + STEP;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .valid     (head_valid),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects, PC wrap and async reset.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        misaligned;
  logic        misaligned_hi;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] e;

  fetch_if #(.XLEN(32)) bus ();
  fetch_if #(.XLEN(32)) bus_hi ();

  always #5 clock = ~clock;

  // Instruction memory: one-cycle read latency, contents derived from the address.
  always @(posedge clock) begin
    bus.imem_rdata    <= bus.imem_addr ^ KEY;
    bus_hi.imem_rdata <= bus_hi.imem_addr ^ KEY;
  end

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .bus             (bus),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .misaligned      (misaligned)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_hi (
    .clock           (clock),
    .reset_n         (reset_n),
    .bus             (bus_hi),
    .redirect_valid  (1'b0),
    .redirect_target (32'h0),
    .misaligned      (misaligned_hi)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] tgt);
    @(negedge clock);
    bus.instr_ready = rdy;
    redirect_valid  = redir;
    redirect_target = tgt;
    #1;
  endtask

  task automatic applyReset(input logic rdy);
    @(negedge clock);
    reset_n            = 1'b0;
    redirect_valid     = 1'b0;
    redirect_target    = '0;
    bus.instr_ready    = rdy;
    bus_hi.instr_ready = 1'b1;
    #1;
    checkOutput("rst_req", bus.imem_req, 0);
    checkOutput("rst_valid", bus.instr_valid, 0);
    checkOutput("rst_misaligned", misaligned, 0);
    checkOutput("rst_hi_req", bus_hi.imem_req, 0);
    checkOutput("rst_hi_misaligned", misaligned_hi, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    // Streaming from reset, with the wrapping-PC instance checked alongside
    applyReset(1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("t1_req", bus.imem_req, 1);
      checkOutput("t1_addr", bus.imem_addr, 32'(4 * k));
      checkOutput("t1_valid", bus.instr_valid, (k >= 2));
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      checkOutput("t5_addr", bus_hi.imem_addr, e);
      if (k >= 2) begin
        checkOutput("t1_pc", bus.instr_pc, 32'(4 * (k - 2)));
        checkOutput("t1_instr", bus.instr, 32'(4 * (k - 2)) ^ KEY);
        checkOutput("t1_pc4", bus.instr_pc_plus4, 32'(4 * (k - 1)));
        e = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
        checkOutput("t5_pc", bus_hi.instr_pc, e);
        checkOutput("t5_instr", bus_hi.instr, e ^ KEY);
        e = e + 32'd4;
        checkOutput("t5_pc4", bus_hi.instr_pc_plus4, e);
      end
    end

    // Back-pressure: exactly DEPTH requests, then stall, then drain in order
    applyReset(1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t2_fill_req", bus.imem_req, 1);
      checkOutput("t2_fill_addr", bus.imem_addr, 32'(4 * k));
    end
    for (int j = 0; j < 2; j++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t2_stall_req", bus.imem_req, 0);
      checkOutput("t2_stall_valid", bus.instr_valid, 1);
      checkOutput("t2_stall_pc", bus.instr_pc, 0);
    end
    checkOutput("t2_count", dut.u_fifo.count, 4);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("t2_drain_valid", bus.instr_valid, 1);
      checkOutput("t2_drain_pc", bus.instr_pc, 32'(4 * k));
      checkOutput("t2_drain_instr", bus.instr, 32'(4 * k) ^ KEY);
      checkOutput("t2_drain_req", bus.imem_req, 1);
      checkOutput("t2_drain_addr", bus.imem_addr, 32'h10 + 32'(4 * k));
    end

    // Redirect while 0x10 is in flight and three entries are buffered
    applyReset(1'b0);
    for (int j = 0; j < 5; j++) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t3_pre_addr", bus.imem_addr, 32'h10);
    applyStimulus(1'b1, 1'b1, 32'h400);
    checkOutput("t3_redir_req", bus.imem_req, 0);
    checkOutput("t3_redir_count", dut.u_fifo.count, 3);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t3_flush_valid", bus.instr_valid, 0);
    checkOutput("t3_req", bus.imem_req, 1);
    checkOutput("t3_addr", bus.imem_addr, 32'h400);
    checkOutput("t3_misaligned", misaligned, 0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t3_drop_valid", bus.instr_valid, 0);
    checkOutput("t3_addr2", bus.imem_addr, 32'h404);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t3_first_valid", bus.instr_valid, 1);
    checkOutput("t3_first_pc", bus.instr_pc, 32'h400);
    checkOutput("t3_first_instr", bus.instr, 32'h400 ^ KEY);

    // Misaligned redirect, then two back-to-back redirects
    applyStimulus(1'b1, 1'b1, 32'h402);
    checkOutput("t4_redir_req", bus.imem_req, 0);
    checkOutput("t4_mis_early", misaligned, 0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t4_mis_pulse", misaligned, 1);
    checkOutput("t4_addr", bus.imem_addr, 32'h400);
    checkOutput("t4_valid", bus.instr_valid, 0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t4_mis_clear", misaligned, 0);
    checkOutput("t4_addr2", bus.imem_addr, 32'h404);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t4_pc", bus.instr_pc, 32'h400);
    applyStimulus(1'b1, 1'b1, 32'h100);
    checkOutput("t4_b2b_req1", bus.imem_req, 0);
    applyStimulus(1'b1, 1'b1, 32'h200);
    checkOutput("t4_b2b_req2", bus.imem_req, 0);
    checkOutput("t4_b2b_valid", bus.instr_valid, 0);
    checkOutput("t4_b2b_mis", misaligned, 0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t4_b2b_addr", bus.imem_addr, 32'h200);
    checkOutput("t4_b2b_valid2", bus.instr_valid, 0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t4_b2b_addr2", bus.imem_addr, 32'h204);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t4_b2b_pc", bus.instr_pc, 32'h200);
    checkOutput("t4_b2b_instr", bus.instr, 32'h200 ^ KEY);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t4_b2b_pc2", bus.instr_pc, 32'h204);

    // Asynchronous reset mid-cycle with two entries buffered
    applyReset(1'b0);
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t6_count", dut.u_fifo.count, 2);
    checkOutput("t6_pre_valid", bus.instr_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", bus.instr_valid, 0);
    checkOutput("t6_async_req", bus.imem_req, 0);
    @(negedge clock);
    reset_n = 1'b1;
    bus.instr_ready = 1'b1;
    #1;
    checkOutput("t6_restart_req", bus.imem_req, 1);
    checkOutput("t6_restart_addr", bus.imem_addr, 32'h0);
    checkOutput("t6_restart_valid", bus.instr_valid, 0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t6_no_stale", bus.instr_valid, 0);
    checkOutput("t6_addr", bus.imem_addr, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t6_valid", bus.instr_valid, 1);
    checkOutput("t6_pc", bus.instr_pc, 32'h0);
    checkOutput("t6_instr", bus.instr, KEY);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t6_pc2", bus.instr_pc, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
